// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg : shared constants, FSM encoding and helpers for IF stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if : instruction-memory req/gnt + rvalid handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit_skid.sv
// ----------------------------------------------------------------------------
// if_skid_buffer : single-entry {instr, pc} holding slot for stalled responses
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_skid_buffer
  import if_fetch_unit_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        load,
  input  wire logic        drain,
  input  wire logic [31:0] in_instr,
  input  wire logic [31:0] in_pc,
  output logic             full,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full      <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
    end else if (load) begin
      full      <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
    end else if (drain) begin
      full      <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit : IF stage - PC, imem fetch handshake, IF/ID register + skid
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               stall,
  input  wire logic               if_jump,
  input  wire logic [31:0]        next_pc,
  if_fetch_unit_if.master         imem,
  output logic                    id_valid,
  output logic [31:0]             id_instr,
  output logic [31:0]             id_pc,
  output logic [31:0]             id_pc_4
);

  fetch_state_e state;
  logic         req_q;
  logic [31:0]  pc;
  logic [31:0]  inflight_pc;
  logic         pend_valid;
  logic [31:0]  pend_target;

  logic         skid_full;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  logic granted;
  logic resp;
  logic advance;
  logic park;
  logic drain;
  logic accept_jump;
  logic slot_pending;

  assign imem.req  = req_q;
  assign imem.addr = {pc[31:2], 2'b00};

  assign granted      = (state == ST_FETCH) && req_q && imem.gnt;
  assign resp         = (state == ST_WAIT) && imem.rvalid;
  assign advance      = !stall || !id_valid;
  assign park         = resp && id_valid && stall;
  assign drain        = advance && skid_full;
  assign accept_jump  = if_jump && id_valid && !stall;
  // Delay slot still unfetched: defer the redirect to the grant after it
  assign slot_pending = (pc == id_pc_4) && !granted;

  // req is registered from the next state so it is low throughout reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_FETCH;
      req_q       <= 1'b0;
      inflight_pc <= 32'd0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (granted) begin
            state       <= ST_WAIT;
            req_q       <= 1'b0;
            inflight_pc <= pc;
          end else begin
            req_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (resp) begin
            state <= park ? ST_HOLD : ST_FETCH;
            req_q <= !park;
          end
        end
        ST_HOLD: begin
          if (drain) begin
            state <= ST_FETCH;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_FETCH;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      if (accept_jump && !slot_pending) begin
        pc <= next_pc;
      end else if (granted) begin
        pc <= pend_valid ? pend_target : pc_inc(pc);
      end
      if (granted) begin
        pend_valid <= 1'b0;
      end
      if (accept_jump && slot_pending) begin
        pend_valid  <= 1'b1;
        pend_target <= next_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= 32'd0;
      id_pc    <= 32'd0;
      id_pc_4  <= 32'd0;
    end else if (advance) begin
      if (skid_full) begin
        id_valid <= 1'b1;
        id_instr <= skid_instr;
        id_pc    <= skid_pc;
        id_pc_4  <= pc_inc(skid_pc);
      end else if (resp) begin
        id_valid <= 1'b1;
        id_instr <= imem.rdata;
        id_pc    <= inflight_pc;
        id_pc_4  <= pc_inc(inflight_pc);
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

  if_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (park),
    .drain     (drain),
    .in_instr  (imem.rdata),
    .in_pc     (inflight_pc),
    .full      (skid_full),
    .out_instr (skid_instr),
    .out_pc    (skid_pc)
  );

endmodule

`default_nettype wire
